// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage RISC-V core control path.
//   RESULT_SEL_* : writeback result select encodings
//   FWD_*        : EX-stage ALU operand forwarding selects
//   mem_state_e  : data-memory handshake state in hazard_ctrl
package cpu_pkg;
  localparam logic [1:0] RESULT_SEL_ALU = 2'b00;
  localparam logic [1:0] RESULT_SEL_MEM = 2'b01;
  localparam logic [1:0] RESULT_SEL_PC4 = 2'b10;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;
endpackage

// File: rtl/forward_unit.sv
// Combinational forwarding select for one EX-stage ALU operand.
//   rs_ID_EX                 : source register of the operand in EX
//   rd_EX_MEM / rd_MEM_WB    : destinations of the two younger-result stages
//   reg_write_EX_MEM/_MEM_WB : writeback enables of those stages
//   fwd_sel                  : FWD_MEM, FWD_WB or FWD_RF
module forward_unit
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs_ID_EX,
  input  logic [REG_ADDR_WIDTH-1:0] rd_EX_MEM,
  input  logic [REG_ADDR_WIDTH-1:0] rd_MEM_WB,
  input  logic                      reg_write_EX_MEM,
  input  logic                      reg_write_MEM_WB,
  output logic [1:0]                fwd_sel
);
  // EX/MEM holds the newer value, so it is checked first. x0 never forwards.
  always_comb begin
    fwd_sel = FWD_RF;
    if (reg_write_EX_MEM && (rd_EX_MEM != '0) && (rd_EX_MEM == rs_ID_EX))
      fwd_sel = FWD_MEM;
    else if (reg_write_MEM_WB && (rd_MEM_WB != '0) && (rd_MEM_WB == rs_ID_EX))
      fwd_sel = FWD_WB;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stall/flush strobes for PC and all pipeline
// registers, EX forwarding selects, data-memory req/ack handshake and
// saturating stall/flush performance counters.
//   cpu_clk, cpu_rst          : clock, synchronous active-high reset
//   *_IF_ID/*_ID_EX/...       : register fields and controls of each stage
//   mem_access_MEM, dmem_ack  : MEM-stage access and memory completion
//   pc_src_EX                 : taken branch/jump in EX
//   dmem_req                  : one-cycle request pulse to data memory
//   stall_*, flush_*          : combinational pipeline strobes
//   forward_a/b               : ALU operand selects
//   stall_cnt, flush_cnt      : saturating performance counters
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      cpu_clk,
  input  logic                      cpu_rst,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_IF_ID,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_IF_ID,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_ID_EX,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_ID_EX,
  input  logic [REG_ADDR_WIDTH-1:0] rd_ID_EX,
  input  logic                      reg_write_ID_EX,
  input  logic [1:0]                result_sel_ID_EX,
  input  logic [REG_ADDR_WIDTH-1:0] rd_EX_MEM,
  input  logic [REG_ADDR_WIDTH-1:0] rd_MEM_WB,
  input  logic                      reg_write_EX_MEM,
  input  logic                      reg_write_MEM_WB,
  input  logic                      mem_access_MEM,
  input  logic                      pc_src_EX,
  input  logic                      dmem_ack,
  output logic                      dmem_req,
  output logic                      stall_PC,
  output logic                      stall_IF_ID,
  output logic                      stall_ID_EX,
  output logic                      stall_EX_MEM,
  output logic                      stall_MEM_WB,
  output logic                      flush_IF_ID,
  output logic                      flush_ID_EX,
  output logic [1:0]                forward_a,
  output logic [1:0]                forward_b,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt
);
  mem_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
  logic                 mem_stall, load_use, any_stall, any_flush;

  // Memory handshake. The request is Mealy on RUN so the pulse lands in the
  // same cycle the access reaches MEM; ack is only honoured in WAIT.
  always_comb begin
    state_d   = state_q;
    dmem_req  = 1'b0;
    mem_stall = 1'b0;
    case (state_q)
      ST_RUN: if (mem_access_MEM) begin
        dmem_req  = 1'b1;
        mem_stall = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: if (dmem_ack) state_d = ST_RUN;
               else          mem_stall = 1'b1;
      default: state_d = ST_RUN;
    endcase
  end

  assign load_use = reg_write_ID_EX && (result_sel_ID_EX == RESULT_SEL_MEM) &&
                    (rd_ID_EX != '0) &&
                    ((rd_ID_EX == rs1_IF_ID) || (rd_ID_EX == rs2_IF_ID));

  // While memory is outstanding EX is frozen, so redirect/load-use are simply
  // held off and re-evaluated on release.
  always_comb begin
    stall_PC     = 1'b0;
    stall_IF_ID  = 1'b0;
    stall_ID_EX  = 1'b0;
    stall_EX_MEM = 1'b0;
    stall_MEM_WB = 1'b0;
    flush_IF_ID  = 1'b0;
    flush_ID_EX  = 1'b0;
    if (mem_stall) begin
      stall_PC     = 1'b1;
      stall_IF_ID  = 1'b1;
      stall_ID_EX  = 1'b1;
      stall_EX_MEM = 1'b1;
      stall_MEM_WB = 1'b1;
    end else if (pc_src_EX) begin
      flush_IF_ID = 1'b1;
      flush_ID_EX = 1'b1;
    end else if (load_use) begin
      stall_PC    = 1'b1;
      stall_IF_ID = 1'b1;
      flush_ID_EX = 1'b1;
    end
  end

  // Operand a = index 0, operand b = index 1.
  logic [1:0][REG_ADDR_WIDTH-1:0] rs_ex;
  logic [1:0][1:0]                fwd_sel;
  assign rs_ex = {rs2_ID_EX, rs1_ID_EX};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    forward_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd (
      .rs_ID_EX        (rs_ex[g]),
      .rd_EX_MEM       (rd_EX_MEM),
      .rd_MEM_WB       (rd_MEM_WB),
      .reg_write_EX_MEM(reg_write_EX_MEM),
      .reg_write_MEM_WB(reg_write_MEM_WB),
      .fwd_sel         (fwd_sel[g])
    );
  end

  assign forward_a = fwd_sel[0];
  assign forward_b = fwd_sel[1];

  assign any_stall = stall_PC | stall_IF_ID | stall_ID_EX | stall_EX_MEM | stall_MEM_WB;
  assign any_flush = flush_IF_ID | flush_ID_EX;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (any_stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (any_flush && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  localparam int RW = 5;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          cpu_clk = 1'b0;
  logic          cpu_rst;
  logic [RW-1:0] rs1_IF_ID, rs2_IF_ID, rs1_ID_EX, rs2_ID_EX, rd_ID_EX;
  logic          reg_write_ID_EX;
  logic [1:0]    result_sel_ID_EX;
  logic [RW-1:0] rd_EX_MEM, rd_MEM_WB;
  logic          reg_write_EX_MEM, reg_write_MEM_WB;
  logic          mem_access_MEM, pc_src_EX, dmem_ack;
  logic          dmem_req;
  logic          stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB;
  logic          flush_IF_ID, flush_ID_EX;
  logic [1:0]    forward_a, forward_b;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  hazard_ctrl #(.REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .rs1_IF_ID(rs1_IF_ID), .rs2_IF_ID(rs2_IF_ID),
    .rs1_ID_EX(rs1_ID_EX), .rs2_ID_EX(rs2_ID_EX), .rd_ID_EX(rd_ID_EX),
    .reg_write_ID_EX(reg_write_ID_EX), .result_sel_ID_EX(result_sel_ID_EX),
    .rd_EX_MEM(rd_EX_MEM), .rd_MEM_WB(rd_MEM_WB),
    .reg_write_EX_MEM(reg_write_EX_MEM), .reg_write_MEM_WB(reg_write_MEM_WB),
    .mem_access_MEM(mem_access_MEM), .pc_src_EX(pc_src_EX), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req),
    .stall_PC(stall_PC), .stall_IF_ID(stall_IF_ID), .stall_ID_EX(stall_ID_EX),
    .stall_EX_MEM(stall_EX_MEM), .stall_MEM_WB(stall_MEM_WB),
    .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
    .forward_a(forward_a), .forward_b(forward_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Observed strobes packed {PC, IF_ID, ID_EX, EX_MEM, MEM_WB} and {IF_ID, ID_EX}.
  wire [4:0] obs_stall = {stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB};
  wire [1:0] obs_flush = {flush_IF_ID, flush_ID_EX};

  // ---------------- reference model ----------------
  // "outstanding" = a memory access has been requested and not yet acknowledged.
  bit outstanding = 0;
  int m_scnt = 0, m_fcnt = 0;

  typedef struct packed {
    logic       req;
    logic [4:0] stall;
    logic [1:0] flush;
    logic [1:0] fa;
    logic [1:0] fb;
  } exp_t;

  function automatic logic [1:0] ref_fwd(input logic [RW-1:0] rs);
    if (reg_write_EX_MEM && rd_EX_MEM != 0 && rd_EX_MEM == rs) return 2'b10;
    if (reg_write_MEM_WB && rd_MEM_WB != 0 && rd_MEM_WB == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t ref_eval();
    exp_t e;
    bit frozen, lu;
    e = '0;
    frozen = outstanding ? !dmem_ack : mem_access_MEM;
    e.req  = !outstanding && mem_access_MEM;
    lu = reg_write_ID_EX && result_sel_ID_EX == 2'b01 && rd_ID_EX != 0 &&
         (rd_ID_EX == rs1_IF_ID || rd_ID_EX == rs2_IF_ID);
    if (frozen)          e.stall = 5'b11111;
    else if (pc_src_EX)  e.flush = 2'b11;
    else if (lu) begin   e.stall = 5'b11000; e.flush = 2'b01; end
    e.fa = ref_fwd(rs1_ID_EX);
    e.fb = ref_fwd(rs2_ID_EX);
    return e;
  endfunction

  always @(posedge cpu_clk) begin
    exp_t e;
    e = ref_eval();
    if (cpu_rst) begin
      outstanding = 0; m_scnt = 0; m_fcnt = 0;
    end else begin
      if (e.stall != 0 && m_scnt < CMAX) m_scnt++;
      if (e.flush != 0 && m_fcnt < CMAX) m_fcnt++;
      outstanding = outstanding ? !dmem_ack : mem_access_MEM;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge cpu_clk); #1;
  endtask

  task automatic set_idle();
    rs1_IF_ID = 0; rs2_IF_ID = 0; rs1_ID_EX = 0; rs2_ID_EX = 0; rd_ID_EX = 0;
    reg_write_ID_EX = 0; result_sel_ID_EX = 2'b00;
    rd_EX_MEM = 0; rd_MEM_WB = 0; reg_write_EX_MEM = 0; reg_write_MEM_WB = 0;
    mem_access_MEM = 0; pc_src_EX = 0; dmem_ack = 0;
  endtask

  task automatic do_reset();
    set_idle();
    cpu_rst = 1; tick(); tick(); cpu_rst = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_idle(); cpu_rst = 1; tick(); tick();
    @(negedge cpu_clk);
    total++; if (stall_cnt !== 0 || flush_cnt !== 0) begin bad++;
      $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    total++; if ({dmem_req, obs_stall, obs_flush} !== 8'b0) begin bad++;
      $display("FAIL reset_strobes got %b want 0", {dmem_req, obs_stall, obs_flush}); end
    tick(); cpu_rst = 0;
  endtask

  task automatic test_load_use();
    do_reset();
    reg_write_ID_EX = 1; result_sel_ID_EX = 2'b01; rd_ID_EX = 5; rs1_IF_ID = 5; rs2_IF_ID = 9;
    @(negedge cpu_clk);
    total++; if (obs_stall !== 5'b11000 || obs_flush !== 2'b01) begin bad++;
      $display("FAIL load_use got s=%b f=%b want s=11000 f=01", obs_stall, obs_flush); end
    tick();
    reg_write_ID_EX = 0; result_sel_ID_EX = 2'b00; rd_ID_EX = 0;  // bubble now in EX
    @(negedge cpu_clk);
    total++; if (obs_stall !== 0 || obs_flush !== 0) begin bad++;
      $display("FAIL load_use_clear got s=%b f=%b want 0", obs_stall, obs_flush); end
    total++; if (stall_cnt !== 1 || flush_cnt !== 1) begin bad++;
      $display("FAIL load_use_cnt got %0d/%0d want 1/1", stall_cnt, flush_cnt); end
    // rd = x0 and an ALU result never create a load-use
    rd_ID_EX = 0; reg_write_ID_EX = 1; result_sel_ID_EX = 2'b01; rs1_IF_ID = 0;
    @(negedge cpu_clk);
    total++; if (obs_stall !== 0) begin bad++;
      $display("FAIL load_use_x0 got s=%b want 0", obs_stall); end
    rd_ID_EX = 5; rs1_IF_ID = 5; result_sel_ID_EX = 2'b00;
    @(negedge cpu_clk);
    total++; if (obs_stall !== 0) begin bad++;
      $display("FAIL load_use_alu got s=%b want 0", obs_stall); end
  endtask

  task automatic test_mem_wait();
    int reqs = 0;
    do_reset();
    mem_access_MEM = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge cpu_clk);
      if (dmem_req) reqs++;
      total++; if (obs_stall !== 5'b11111) begin bad++;
        $display("FAIL mem_wait_stall c=%0d got %b want 11111", c, obs_stall); end
      tick();
    end
    dmem_ack = 1;
    @(negedge cpu_clk);
    total++; if (obs_stall !== 0 || dmem_req !== 0) begin bad++;
      $display("FAIL mem_ack_cycle got s=%b req=%b want 0/0", obs_stall, dmem_req); end
    total++; if (reqs != 1) begin bad++;
      $display("FAIL mem_req_count got %0d want 1", reqs); end
    tick(); set_idle();
    @(negedge cpu_clk);
    total++; if (stall_cnt !== 3 || dmem_req !== 0 || obs_stall !== 0) begin bad++;
      $display("FAIL mem_after got cnt=%0d req=%b s=%b want 3/0/0", stall_cnt, dmem_req, obs_stall); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mem_access_MEM = 1; tick();            // req cycle
    dmem_ack = 1; tick();                  // ack cycle (1-cycle latency)
    dmem_ack = 0;                          // next access in MEM
    @(negedge cpu_clk);
    total++; if (dmem_req !== 1 || obs_stall !== 5'b11111) begin bad++;
      $display("FAIL b2b_req got req=%b s=%b want 1/11111", dmem_req, obs_stall); end
    tick();
    @(negedge cpu_clk);
    total++; if (dmem_req !== 0 || stall_cnt !== 2) begin bad++;
      $display("FAIL b2b_wait got req=%b cnt=%0d want 0/2", dmem_req, stall_cnt); end
  endtask

  task automatic test_redirect_lu();
    do_reset();
    reg_write_ID_EX = 1; result_sel_ID_EX = 2'b01; rd_ID_EX = 5; rs2_IF_ID = 5; pc_src_EX = 1;
    @(negedge cpu_clk);
    total++; if (obs_flush !== 2'b11 || obs_stall !== 0) begin bad++;
      $display("FAIL redirect_lu got f=%b s=%b want 11/00000", obs_flush, obs_stall); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    mem_access_MEM = 1; tick();
    pc_src_EX = 1;
    @(negedge cpu_clk);
    total++; if (obs_flush !== 0 || obs_stall !== 5'b11111) begin bad++;
      $display("FAIL redirect_wait got f=%b s=%b want 00/11111", obs_flush, obs_stall); end
    tick(); dmem_ack = 1;
    @(negedge cpu_clk);
    total++; if (obs_flush !== 2'b11 || obs_stall !== 0) begin bad++;
      $display("FAIL redirect_ack got f=%b s=%b want 11/00000", obs_flush, obs_stall); end
  endtask

  task automatic test_forward();
    set_idle();
    rs1_ID_EX = 7; rs2_ID_EX = 3; rd_EX_MEM = 7; rd_MEM_WB = 7;
    reg_write_EX_MEM = 1; reg_write_MEM_WB = 1;
    @(negedge cpu_clk);
    total++; if (forward_a !== 2'b10 || forward_b !== 2'b00) begin bad++;
      $display("FAIL fwd_mem got a=%b b=%b want 10/00", forward_a, forward_b); end
    rs2_ID_EX = 7; reg_write_EX_MEM = 0;
    @(negedge cpu_clk);
    total++; if (forward_a !== 2'b01 || forward_b !== 2'b01) begin bad++;
      $display("FAIL fwd_wb got a=%b b=%b want 01/01", forward_a, forward_b); end
    rs1_ID_EX = 0; rs2_ID_EX = 0; rd_EX_MEM = 0; rd_MEM_WB = 0;
    reg_write_EX_MEM = 1;
    @(negedge cpu_clk);
    total++; if (forward_a !== 2'b00 || forward_b !== 2'b00) begin bad++;
      $display("FAIL fwd_x0 got a=%b b=%b want 00/00", forward_a, forward_b); end
  endtask

  task automatic test_reset_wait();
    do_reset();
    mem_access_MEM = 1; tick(); tick();    // in WAIT
    mem_access_MEM = 0; cpu_rst = 1; tick();
    cpu_rst = 0; dmem_ack = 1;             // late ack
    @(negedge cpu_clk);
    total++; if (dmem_req !== 0 || obs_stall !== 0) begin bad++;
      $display("FAIL rst_wait got req=%b s=%b want 0/0", dmem_req, obs_stall); end
    total++; if (stall_cnt !== 0 || flush_cnt !== 0) begin bad++;
      $display("FAIL rst_wait_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    tick(); dmem_ack = 0; pc_src_EX = 1; tick(); pc_src_EX = 0;
    @(negedge cpu_clk);
    total++; if (stall_cnt !== 0 || flush_cnt !== 1) begin bad++;
      $display("FAIL rst_wait_recount got %0d/%0d want 0/1", stall_cnt, flush_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    mem_access_MEM = 1;
    for (int c = 0; c < 20; c++) tick();
    dmem_ack = 1;
    @(negedge cpu_clk);
    total++; if (stall_cnt !== 4'd15 || flush_cnt !== 0) begin bad++;
      $display("FAIL saturate got %0d/%0d want 15/0", stall_cnt, flush_cnt); end
    tick(); set_idle(); tick();
    @(negedge cpu_clk);
    total++; if (stall_cnt !== 4'd15) begin bad++;
      $display("FAIL saturate_hold got %0d want 15", stall_cnt); end
  endtask

  task automatic test_random();
    exp_t e;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      cpu_rst          = ($urandom_range(0, 59) == 0);
      rs1_IF_ID        = RW'($urandom_range(0, 3));
      rs2_IF_ID        = RW'($urandom_range(0, 3));
      rs1_ID_EX        = RW'($urandom_range(0, 3));
      rs2_ID_EX        = RW'($urandom_range(0, 3));
      rd_ID_EX         = RW'($urandom_range(0, 3));
      rd_EX_MEM        = RW'($urandom_range(0, 3));
      rd_MEM_WB        = RW'($urandom_range(0, 3));
      reg_write_ID_EX  = $urandom_range(0, 1) == 1;
      result_sel_ID_EX = 2'($urandom_range(0, 2));
      reg_write_EX_MEM = $urandom_range(0, 1) == 1;
      reg_write_MEM_WB = $urandom_range(0, 1) == 1;
      mem_access_MEM   = $urandom_range(0, 3) == 0;
      pc_src_EX        = $urandom_range(0, 4) == 0;
      dmem_ack         = $urandom_range(0, 2) == 0;
      @(negedge cpu_clk);
      e = ref_eval();
      total++; if ({dmem_req, obs_stall, obs_flush} !== {e.req, e.stall, e.flush}) begin bad++;
        $display("FAIL rand_strobe c=%0d got %b want %b", c,
                 {dmem_req, obs_stall, obs_flush}, {e.req, e.stall, e.flush}); end
      total++; if ({forward_a, forward_b} !== {e.fa, e.fb}) begin bad++;
        $display("FAIL rand_fwd c=%0d got %b want %b", c, {forward_a, forward_b}, {e.fa, e.fb}); end
      total++; if (int'(stall_cnt) != m_scnt || int'(flush_cnt) != m_fcnt) begin bad++;
        $display("FAIL rand_cnt c=%0d got %0d/%0d want %0d/%0d", c, stall_cnt, flush_cnt, m_scnt, m_fcnt); end
      tick();
    end
    cpu_rst = 0;
  endtask

  initial begin
    set_idle(); cpu_rst = 1;
    test_reset();
    test_load_use();
    test_mem_wait();
    test_back_to_back();
    test_redirect_lu();
    test_redirect_wait();
    test_forward();
    test_reset_wait();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
